// File: rtl/siphash_pkg.sv
// Shared constants, FSM encoding and the SipHash state record for the
// multi-round SipHash core.
package siphash_pkg;

  localparam logic [63:0] IV0 = 64'h736f6d6570736575;
  localparam logic [63:0] IV1 = 64'h646f72616e646f6d;
  localparam logic [63:0] IV2 = 64'h6c7967656e657261;
  localparam logic [63:0] IV3 = 64'h7465646279746573;

  localparam logic [7:0] DOM_64   = 8'hff;
  localparam logic [7:0] DOM_128  = 8'hee;
  localparam logic [7:0] DOM_OUT1 = 8'hdd;

  localparam int ROT_A = 13;
  localparam int ROT_B = 32;
  localparam int ROT_C = 16;
  localparam int ROT_D = 21;
  localparam int ROT_E = 17;
  localparam int ROT_F = 32;

  typedef enum logic [2:0] {
    IDLE,
    COMP_LOOP,
    COMP_END,
    FIN_LOOP,
    OUT0,
    FIN2_LOOP,
    OUT1
  } state_t;

  typedef struct packed {
    logic [63:0] v3;
    logic [63:0] v2;
    logic [63:0] v1;
    logic [63:0] v0;
  } sip_state_t;

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

endpackage

// File: rtl/siphash_round.sv
// One combinational SipRound (add-rotate-xor) over the four state words.
module siphash_round
  import siphash_pkg::*;
(
  input  sip_state_t state_in,
  output sip_state_t state_out
);

  always_comb begin
    logic [63:0] t0, t1, t2, t3;
    t0 = state_in.v0;
    t1 = state_in.v1;
    t2 = state_in.v2;
    t3 = state_in.v3;

    t0 = t0 + t1;
    t1 = rotl64(t1, ROT_A) ^ t0;
    t0 = rotl64(t0, ROT_B);
    t2 = t2 + t3;
    t3 = rotl64(t3, ROT_C) ^ t2;
    t0 = t0 + t3;
    t3 = rotl64(t3, ROT_D) ^ t0;
    t2 = t2 + t1;
    t1 = rotl64(t1, ROT_E) ^ t2;
    t2 = rotl64(t2, ROT_F);

    state_out.v0 = t0;
    state_out.v1 = t1;
    state_out.v2 = t2;
    state_out.v3 = t3;
  end

endmodule

// File: rtl/siphash_multi_core.sv
// SipHash-64/128 core applying up to ROUNDS_PER_CYCLE SipRounds per clock,
// with runtime compression/finalization round counts (zero allowed).
module siphash_multi_core
  import siphash_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         initalize,
  input  logic         compress,
  input  logic         finalize,
  input  logic         long,
  input  logic [3:0]   compression_rounds,
  input  logic [3:0]   final_rounds,
  input  logic [127:0] key,
  input  logic [63:0]  mi,
  output logic         ready,
  output logic [127:0] siphash_word,
  output logic         siphash_word_valid
);

  if (ROUNDS_PER_CYCLE < 1 || ROUNDS_PER_CYCLE > 4) begin : g_bad_rounds
    $error("ROUNDS_PER_CYCLE must be in 1..4");
  end

  localparam logic [3:0] RPC = 4'(ROUNDS_PER_CYCLE);

  state_t      state, state_nxt;
  sip_state_t  v;
  sip_state_t  chain   [ROUNDS_PER_CYCLE+1];
  sip_state_t  rnd_out [ROUNDS_PER_CYCLE];
  logic [3:0]  rem, d_reg, step;
  logic [63:0] mi_reg, v_xor;
  logic        long_reg;

  // Stage k only takes effect while k < rem, so a partial last cycle bypasses the tail.
  assign chain[0] = v;
  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    siphash_round u_round (
      .state_in  (chain[g]),
      .state_out (rnd_out[g])
    );
    assign chain[g+1] = (4'(g) < rem) ? rnd_out[g] : chain[g];
  end

  assign step  = (rem < RPC) ? rem : RPC;
  assign v_xor = v.v0 ^ v.v1 ^ v.v2 ^ v.v3;
  assign ready = (state == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (initalize)     state_nxt = IDLE;
        else if (compress) state_nxt = (compression_rounds == 4'd0) ? COMP_END : COMP_LOOP;
        else if (finalize) state_nxt = (final_rounds == 4'd0) ? OUT0 : FIN_LOOP;
      end
      COMP_LOOP: if (rem <= RPC) state_nxt = COMP_END;
      COMP_END:  state_nxt = IDLE;
      FIN_LOOP:  if (rem <= RPC) state_nxt = OUT0;
      OUT0: begin
        if (!long_reg)          state_nxt = IDLE;
        else if (d_reg == 4'd0) state_nxt = OUT1;
        else                    state_nxt = FIN2_LOOP;
      end
      FIN2_LOOP: if (rem <= RPC) state_nxt = OUT1;
      OUT1:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v                  <= '0;
      rem                <= '0;
      d_reg              <= '0;
      mi_reg             <= '0;
      long_reg           <= 1'b0;
      siphash_word       <= '0;
      siphash_word_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (initalize) begin
            v.v0               <= key[63:0]   ^ IV0;
            v.v1               <= key[127:64] ^ IV1 ^ {56'd0, (long ? DOM_128 : 8'h00)};
            v.v2               <= key[63:0]   ^ IV2;
            v.v3               <= key[127:64] ^ IV3;
            long_reg           <= long;
            siphash_word_valid <= 1'b0;
          end else if (compress) begin
            v.v3               <= v.v3 ^ mi;
            mi_reg             <= mi;
            rem                <= compression_rounds;
            siphash_word_valid <= 1'b0;
          end else if (finalize) begin
            v.v2[7:0]          <= v.v2[7:0] ^ (long_reg ? DOM_128 : DOM_64);
            rem                <= final_rounds;
            d_reg              <= final_rounds;
            siphash_word_valid <= 1'b0;
          end
        end
        COMP_LOOP, FIN_LOOP, FIN2_LOOP: begin
          v   <= chain[ROUNDS_PER_CYCLE];
          rem <= rem - step;
        end
        COMP_END: v.v0 <= v.v0 ^ mi_reg;
        OUT0: begin
          siphash_word[63:0] <= v_xor;
          if (long_reg) begin
            v.v1[7:0] <= v.v1[7:0] ^ DOM_OUT1;
            rem       <= d_reg;
          end else begin
            siphash_word[127:64] <= '0;
            siphash_word_valid   <= 1'b1;
          end
        end
        OUT1: begin
          siphash_word[127:64] <= v_xor;
          siphash_word_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_siphash_multi_core.sv
// Bench for siphash_multi_core: one instance per ROUNDS_PER_CYCLE (1..4) on
// shared stimulus, expected digests queued per hash and compared on completion.
module tb_siphash_multi_core;

  logic         clk = 1'b0;
  logic         reset_n, initalize, compress, finalize, long;
  logic [3:0]   compression_rounds, final_rounds;
  logic [127:0] key;
  logic [63:0]  mi;
  logic [3:0]   rdy, vld;
  logic [127:0] word [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    siphash_multi_core #(.ROUNDS_PER_CYCLE(g + 1)) u_dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .initalize          (initalize),
      .compress           (compress),
      .finalize           (finalize),
      .long               (long),
      .compression_rounds (compression_rounds),
      .final_rounds       (final_rounds),
      .key                (key),
      .mi                 (mi),
      .ready              (rdy[g]),
      .siphash_word       (word[g]),
      .siphash_word_valid (vld[g])
    );
  end

  localparam logic [127:0] KEY0 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] VEC64  = {64'h0, 64'h726fdb47dd0e0e31};
  localparam logic [127:0] VEC128 = {64'h930255c71472f66d, 64'he6a825ba047f81a3};

  int checks = 0;
  int failures = 0;
  logic [127:0] sb [$];
  int           lowc [4];
  int           comp_low [4];
  logic [3:0]   vld_at, vld_first, rst_rdy, rst_vld;
  logic [127:0] rst_word [4];

  // Reference SipHash model
  logic [63:0] mv [4];
  logic        mlong;

  function automatic logic [63:0] rl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  function automatic void m_round();
    mv[0] = mv[0] + mv[1]; mv[1] = rl(mv[1], 13); mv[1] ^= mv[0]; mv[0] = rl(mv[0], 32);
    mv[2] = mv[2] + mv[3]; mv[3] = rl(mv[3], 16); mv[3] ^= mv[2];
    mv[0] = mv[0] + mv[3]; mv[3] = rl(mv[3], 21); mv[3] ^= mv[0];
    mv[2] = mv[2] + mv[1]; mv[1] = rl(mv[1], 17); mv[1] ^= mv[2]; mv[2] = rl(mv[2], 32);
  endfunction

  function automatic void m_init(input logic [127:0] k, input logic lng);
    mv[0] = k[63:0]   ^ 64'h736f6d6570736575;
    mv[1] = k[127:64] ^ 64'h646f72616e646f6d ^ (lng ? 64'hee : 64'h0);
    mv[2] = k[63:0]   ^ 64'h6c7967656e657261;
    mv[3] = k[127:64] ^ 64'h7465646279746573;
    mlong = lng;
  endfunction

  function automatic void m_compress(input logic [63:0] m, input int c);
    mv[3] ^= m;
    for (int i = 0; i < c; i++) m_round();
    mv[0] ^= m;
  endfunction

  function automatic logic [127:0] m_final(input int d);
    logic [63:0] lo, hi;
    mv[2] ^= (mlong ? 64'hee : 64'hff);
    for (int i = 0; i < d; i++) m_round();
    lo = mv[0] ^ mv[1] ^ mv[2] ^ mv[3];
    if (!mlong) return {64'h0, lo};
    mv[1] ^= 64'hdd;
    for (int i = 0; i < d; i++) m_round();
    hi = mv[0] ^ mv[1] ^ mv[2] ^ mv[3];
    return {hi, lo};
  endfunction

  function automatic int nq(input int x, input int r);
    return (x + r - 1) / r;
  endfunction

  // kind: 0 init, 1 compress, 2 finalize, 3 init+compress together
  task automatic issue(input int kind, input int inject_at, input int rst_at);
    int t;
    t = 0;
    while (rdy != 4'hf && t < 100) begin
      @(negedge clk);
      t++;
    end
    initalize = (kind == 0 || kind == 3);
    compress  = (kind == 1 || kind == 3);
    finalize  = (kind == 2);
    @(posedge clk);
    @(negedge clk);
    initalize = 1'b0;
    compress  = 1'b0;
    finalize  = 1'b0;
    for (int i = 0; i < 4; i++) lowc[i] = -1;
    vld_first = vld;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clk);
      compress = (k == inject_at);
      if (k == rst_at) begin
        reset_n = 1'b0;
        #1;
        rst_rdy = rdy;
        rst_vld = vld;
        for (int i = 0; i < 4; i++) rst_word[i] = word[i];
        break;
      end
      for (int i = 0; i < 4; i++)
        if (lowc[i] < 0 && rdy[i]) begin
          lowc[i]   = k - 1;
          vld_at[i] = vld[i];
        end
      if (lowc[0] >= 0 && lowc[1] >= 0 && lowc[2] >= 0 && lowc[3] >= 0) break;
    end
    compress = 1'b0;
  endtask

  task automatic hash(input logic [127:0] k, input logic lng, input logic [63:0] m,
                      input logic [3:0] c, input logic [3:0] d, input int inject_at);
    key  = k;
    long = lng;
    issue(0, 0, 0);
    mi = m;
    compression_rounds = c;
    issue(1, 0, 0);
    for (int i = 0; i < 4; i++) comp_low[i] = lowc[i];
    mi = ~64'h0;
    final_rounds = d;
    issue(2, inject_at, 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    initalize = 1'b0; compress = 1'b0; finalize = 1'b0; long = 1'b0;
    compression_rounds = 4'd0; final_rounds = 4'd0; key = '0; mi = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdy[i] !== 1'b1 || vld[i] !== 1'b0 || word[i] !== 128'h0) begin
        failures++;
        $display("FAIL reset[R=%0d]: ready=%b valid=%b word=%h, need 1 0 0", i + 1, rdy[i], vld[i], word[i]);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_hash(input string name, input logic [3:0] c, input logic [3:0] d, input logic lng);
    logic [127:0] e;
    int r, ef;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      r  = i + 1;
      ef = lng ? 2 * nq(int'(d), r) + 2 : nq(int'(d), r) + 1;
      checks++;
      if (word[i] !== e) begin
        failures++;
        $display("FAIL %s_word[R=%0d]: got %h expected %h", name, r, word[i], e);
      end
      checks++;
      if (lowc[i] != ef || vld_at[i] !== 1'b1) begin
        failures++;
        $display("FAIL %s_fin_timing[R=%0d]: busy=%0d valid=%b expected busy=%0d valid=1", name, r, lowc[i], vld_at[i], ef);
      end
      checks++;
      if (comp_low[i] != nq(int'(c), r) + 1) begin
        failures++;
        $display("FAIL %s_comp_timing[R=%0d]: busy=%0d expected %0d", name, r, comp_low[i], nq(int'(c), r) + 1);
      end
    end
  endtask

  task automatic test_vectors();
    sb.push_back(VEC64);
    hash(KEY0, 1'b0, 64'h0, 4'd2, 4'd4, 0);
    check_hash("vec64", 4'd2, 4'd4, 1'b0);
    sb.push_back(VEC128);
    hash(KEY0, 1'b1, 64'h0, 4'd2, 4'd4, 0);
    check_hash("vec128", 4'd2, 4'd4, 1'b1);
  endtask

  task automatic test_zero_rounds();
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    mi = 64'h0123456789abcdef;
    compression_rounds = 4'd0;
    issue(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lowc[i] != 1 || vld_first[i] !== 1'b0) begin
        failures++;
        $display("FAIL comp_c0[R=%0d]: busy=%0d valid=%b expected busy=1 valid=0", i + 1, lowc[i], vld_first[i]);
      end
    end
    sb.push_back({64'h0, k[63:0] ^ 64'h736f6d6570736575 ^ k[127:64] ^ 64'h646f72616e646f6d ^
                  k[63:0] ^ 64'h6c7967656e657261 ^ 64'hff ^ k[127:64] ^ 64'h7465646279746573});
    hash(k, 1'b0, 64'h55aa, 4'd0, 4'd0, 0);
    check_hash("zero64", 4'd0, 4'd0, 1'b0);
    m_init(k, 1'b1);
    m_compress(64'h55aa, 0);
    sb.push_back(m_final(0));
    hash(k, 1'b1, 64'h55aa, 4'd0, 4'd0, 0);
    check_hash("zero128", 4'd0, 4'd0, 1'b1);
  endtask

  task automatic test_ignore();
    key  = KEY0;
    long = 1'b0;
    mi   = 64'hdeadbeefcafef00d;
    compression_rounds = 4'd2;
    issue(3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lowc[i] != 0) begin
        failures++;
        $display("FAIL init_wins[R=%0d]: busy=%0d expected 0", i + 1, lowc[i]);
      end
    end
    // Injected compress during finalize must be dropped
    sb.push_back(VEC64);
    mi = 64'h0;
    issue(1, 0, 0);
    for (int i = 0; i < 4; i++) comp_low[i] = lowc[i];
    mi = ~64'h0;
    final_rounds = 4'd4;
    issue(2, 1, 0);
    check_hash("ignore", 4'd2, 4'd4, 1'b0);
  endtask

  task automatic test_reset_mid();
    hash(KEY0, 1'b1, 64'h0, 4'd2, 4'd4, 0);
    key = KEY0; long = 1'b1;
    issue(0, 0, 0);
    mi = 64'h0; compression_rounds = 4'd2;
    issue(1, 0, 0);
    final_rounds = 4'd4;
    issue(2, 0, 3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rst_rdy[i] !== 1'b1 || rst_vld[i] !== 1'b0 || rst_word[i] !== 128'h0) begin
        failures++;
        $display("FAIL reset_mid[R=%0d]: ready=%b valid=%b word=%h, need 1 0 0", i + 1, rst_rdy[i], rst_vld[i], rst_word[i]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    sb.push_back(VEC128);
    hash(KEY0, 1'b1, 64'h0, 4'd2, 4'd4, 0);
    check_hash("after_reset", 4'd2, 4'd4, 1'b1);
  endtask

  task automatic test_odd_rounds();
    logic [127:0] k;
    logic [63:0]  m;
    for (int l = 0; l < 2; l++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      m = {$urandom, $urandom};
      m_init(k, l[0]);
      m_compress(m, 3);
      sb.push_back(m_final(5));
      hash(k, l[0], m, 4'd3, 4'd5, 0);
      check_hash(l[0] ? "odd128" : "odd64", 4'd3, 4'd5, l[0]);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_zero_rounds();
    test_ignore();
    test_reset_mid();
    test_odd_rounds();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
